fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter Psize, default 4, program address width.
REQ-002 SHALL have parameter Isize, default 24; instruction word is Isize+1 bits ([Isize:0]).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin execution from IDLE; return to IDLE from HALT.
REQ-006 SHALL have port I  input  Isize+1  instruction read combinationally from program memory at address.
REQ-007 SHALL have port branch_en  input  1  executing instruction (ir) takes a branch.
REQ-008 SHALL have port branch_abs  input  1  1 = absolute target, 0 = ir_pc-relative target.
REQ-009 SHALL have port branch_off  input  Psize  absolute target or relative offset, two's-complement-agnostic modulo add.
REQ-010 SHALL have port wait_req  input  1  executing instruction requires external acknowledge.
REQ-011 SHALL have port ext_ack  input  1  external acknowledge level (e.g. push switch).
REQ-012 SHALL have port halt_req  input  1  executing instruction is a halt.
REQ-013 SHALL have port address  output  Psize  program memory address, equals pc register.
REQ-014 SHALL have port ir  output  Isize+1  instruction register.
REQ-015 SHALL have port ir_pc  output  Psize  address from which ir was fetched.
REQ-016 SHALL have port ir_valid  output  1  ir holds an instruction to execute.
REQ-017 SHALL have port state  output  2  IDLE=00, RUN=01, WAIT=10, HALT=11.
REQ-018 SHALL have port halted  output  1  high exactly when state=HALT.

Function
REQ-019 SHALL compute ack_rise = ext_ack & ~ack_q, ack_q registered ext_ack; only ack_rise releases WAIT.
REQ-020 IDLE: pc, ir, ir_pc held; ir_valid=0; on start -> RUN, ir<=I, ir_pc<=pc, pc<=pc+1, ir_valid<=1.
REQ-021 RUN with ir_valid=0: ir<=I, ir_pc<=pc, pc<=pc+1, ir_valid<=1; branch_en/wait_req/halt_req ignored.
REQ-022 RUN with ir_valid=1, priority halt_req > wait_req > branch_en > sequential.
REQ-023 halt_req: -> HALT, ir_valid<=0, pc and ir held.
REQ-024 wait_req: -> WAIT; pc, ir, ir_pc, ir_valid held.
REQ-025 branch_en: pc<=target, ir_valid<=0 (fetched wrong-path word discarded); target = branch_abs ? branch_off : ir_pc+branch_off mod 2^Psize; one-cycle bubble.
REQ-026 sequential: ir<=I, ir_pc<=pc, pc<=pc+1, ir_valid<=1 (one instruction per cycle).
REQ-027 WAIT: hold all registers until ack_rise; on ack_rise -> RUN performing the REQ-026 sequential fetch in the same cycle.
REQ-028 WAIT: halt_req, branch_en, wait_req, start ignored; ext_ack already high on entry does not release (edge needed).
REQ-029 HALT: all registers held; start -> IDLE with pc<=0, ir_valid=0.
REQ-030 pc+1 and relative add SHALL wrap 2^Psize-1 -> 0 with no flag.
REQ-031 start in RUN or WAIT SHALL be ignored.

Reset
REQ-032 reset SHALL take priority over all inputs in the cycle asserted, including mid-WAIT and mid-branch.
REQ-033 On reset: state=IDLE, pc=0, address=0, ir=0, ir_pc=0, ir_valid=0, halted=0, ack_q=0.

Verification
REQ-034 Psize=4, prog[k]=k; reset, start pulse -> ir=0,1,2,... on consecutive cycles, ir_valid=1 from cycle after start, address leads ir_pc by 1.
REQ-035 ir_pc=5 with branch_en=1, branch_abs=0, branch_off=4'hE -> next cycle ir_valid=0, address=3; following cycle ir=prog[3], ir_pc=3.
REQ-036 run to ir_pc=15 sequentially -> address=0 next, ir_pc=0 after; branch_abs=1, off=9 at ir_pc=15 -> address=9.
REQ-037 wait_req at ir_pc=4 with ext_ack held high -> stays WAIT; ack low 1 cycle then high -> RUN, ir_pc=5 the cycle after the rising edge.
REQ-038 halt_req and branch_en both high at ir_pc=7 -> state=11, halted=1, pc unchanged; start -> IDLE, address=0; start -> ir=prog[0].
REQ-039 reset asserted in WAIT and in HALT -> next cycle all outputs equal REQ-033 values.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: pc/ir pipeline with branch, external-ack wait and halt.
// One instruction per cycle; taken branches cost a one-cycle bubble.
module fetch_sequencer #(
    parameter int Psize = 4,
    parameter int Isize = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [Isize:0]   I,
    input  logic             branch_en,
    input  logic             branch_abs,
    input  logic [Psize-1:0] branch_off,
    input  logic             wait_req,
    input  logic             ext_ack,
    input  logic             halt_req,
    output logic [Psize-1:0] address,
    output logic [Isize:0]   ir,
    output logic [Psize-1:0] ir_pc,
    output logic             ir_valid,
    output logic [1:0]       state,
    output logic             halted
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WAIT = 2'b10,
        HALT = 2'b11
    } state_t;

    state_t           cur, nxt;
    logic [Psize-1:0] pc, pc_n;
    logic [Isize:0]   ir_r, ir_n;
    logic [Psize-1:0] ir_pc_r, ir_pc_n;
    logic             valid_r, valid_n;
    logic             ack_q;
    logic             ack_rise;
    logic [Psize-1:0] target;

    assign ack_rise = ext_ack & ~ack_q;
    assign target   = branch_abs ? branch_off : ir_pc_r + branch_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= IDLE;
            pc      <= '0;
            ir_r    <= '0;
            ir_pc_r <= '0;
            valid_r <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            cur     <= nxt;
            pc      <= pc_n;
            ir_r    <= ir_n;
            ir_pc_r <= ir_pc_n;
            valid_r <= valid_n;
            ack_q   <= ext_ack;
        end
    end

    always_comb begin
        nxt     = cur;
        pc_n    = pc;
        ir_n    = ir_r;
        ir_pc_n = ir_pc_r;
        valid_n = valid_r;
        unique case (cur)
            IDLE: begin
                valid_n = 1'b0;
                if (start) begin
                    nxt     = RUN;
                    ir_n    = I;
                    ir_pc_n = pc;
                    pc_n    = pc + 1'b1;
                    valid_n = 1'b1;
                end
            end
            RUN: begin
                // Control inputs only apply to a valid ir; otherwise refill.
                if (valid_r && halt_req) begin
                    nxt     = HALT;
                    valid_n = 1'b0;
                end else if (valid_r && wait_req) begin
                    nxt = WAIT;
                end else if (valid_r && branch_en) begin
                    pc_n    = target;
                    valid_n = 1'b0;
                end else begin
                    ir_n    = I;
                    ir_pc_n = pc;
                    pc_n    = pc + 1'b1;
                    valid_n = 1'b1;
                end
            end
            WAIT: begin
                if (ack_rise) begin
                    nxt     = RUN;
                    ir_n    = I;
                    ir_pc_n = pc;
                    pc_n    = pc + 1'b1;
                    valid_n = 1'b1;
                end
            end
            HALT: begin
                if (start) begin
                    nxt     = IDLE;
                    pc_n    = '0;
                    valid_n = 1'b0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign address  = pc;
    assign ir       = ir_r;
    assign ir_pc    = ir_pc_r;
    assign ir_valid = valid_r;
    assign state    = cur;
    assign halted   = (cur == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with prog[k] = k.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, branch_en, branch_abs, wait_req, ext_ack, halt_req;
    logic [3:0]  branch_off;
    logic [24:0] I;
    logic [3:0]  address, ir_pc;
    logic [24:0] ir;
    logic        ir_valid, halted;
    logic [1:0]  state;
    int          tests = 0;
    int          fails = 0;

    fetch_sequencer #(.Psize(4), .Isize(24)) dut (
        .clk(clk), .reset(reset), .start(start), .I(I),
        .branch_en(branch_en), .branch_abs(branch_abs),
        .branch_off(branch_off), .wait_req(wait_req),
        .ext_ack(ext_ack), .halt_req(halt_req), .address(address),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .state(state), .halted(halted)
    );

    always #5 clk = ~clk;
    assign I = {21'd0, address};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input logic [3:0] k);
        int n = 0;
        while (!(ir_valid && ir_pc == k) && n < 40) begin
            cyc();
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL run_to timeout: ir_pc=%0d required %0d", ir_pc, k);
        end
    endtask

    task automatic test_reset();
        reset = 1; cyc(); reset = 0;
        tests++;
        if ({state, halted, ir_valid, address, ir_pc, ir} !== 36'd0) begin
            fails++;
            $display("FAIL reset: st=%0d h=%0b v=%0b a=%0d pc=%0d ir=%0d required all 0",
                     state, halted, ir_valid, address, ir_pc, ir);
        end
        cyc();
        tests++;
        if (state !== 2'b00 || ir_valid !== 1'b0 || address !== 4'd0) begin
            fails++;
            $display("FAIL idle_hold: st=%0d v=%0b a=%0d required 0/0/0",
                     state, ir_valid, address);
        end
    endtask

    task automatic test_sequential();
        start = 1; cyc(); start = 0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (state !== 2'b01 || ir !== 25'(k) || ir_pc !== 4'(k) ||
                address !== 4'(k + 1) || ir_valid !== 1'b1) begin
                fails++;
                $display("FAIL seq[%0d]: st=%0d ir=%0d pc=%0d a=%0d v=%0b required 1/%0d/%0d/%0d/1",
                         k, state, ir, ir_pc, address, ir_valid, k, k, k + 1);
            end
            cyc();
        end
    endtask

    task automatic test_start_ignored();
        start = 1; cyc(); start = 0;
        tests++;
        if (state !== 2'b01 || ir_pc !== 4'd5 || ir_valid !== 1'b1) begin
            fails++;
            $display("FAIL start_in_run: st=%0d pc=%0d v=%0b required 1/5/1",
                     state, ir_pc, ir_valid);
        end
    endtask

    task automatic test_branch_rel();
        run_to(4'd5);
        branch_en = 1; branch_abs = 0; branch_off = 4'hE;
        cyc();
        branch_en = 0;
        tests++;
        if (ir_valid !== 1'b0 || address !== 4'd3) begin
            fails++;
            $display("FAIL branch_rel: v=%0b a=%0d required 0/3", ir_valid, address);
        end
        cyc();
        tests++;
        if (ir !== 25'd3 || ir_pc !== 4'd3 || ir_valid !== 1'b1 || address !== 4'd4) begin
            fails++;
            $display("FAIL branch_rel_fetch: ir=%0d pc=%0d v=%0b a=%0d required 3/3/1/4",
                     ir, ir_pc, ir_valid, address);
        end
    endtask

    task automatic test_wrap_and_abs();
        run_to(4'd15);
        tests++;
        if (address !== 4'd0) begin
            fails++;
            $display("FAIL wrap_addr: a=%0d required 0", address);
        end
        cyc();
        tests++;
        if (ir_pc !== 4'd0 || ir !== 25'd0 || address !== 4'd1) begin
            fails++;
            $display("FAIL wrap_pc: pc=%0d ir=%0d a=%0d required 0/0/1", ir_pc, ir, address);
        end
        run_to(4'd15);
        branch_en = 1; branch_abs = 1; branch_off = 4'd9;
        cyc();
        branch_en = 0; branch_abs = 0;
        tests++;
        if (address !== 4'd9 || ir_valid !== 1'b0) begin
            fails++;
            $display("FAIL branch_abs: a=%0d v=%0b required 9/0", address, ir_valid);
        end
        cyc();
        tests++;
        if (ir !== 25'd9 || ir_pc !== 4'd9) begin
            fails++;
            $display("FAIL branch_abs_fetch: ir=%0d pc=%0d required 9/9", ir, ir_pc);
        end
    endtask

    task automatic test_wait();
        run_to(4'd4);
        wait_req = 1; ext_ack = 1;
        cyc();
        wait_req = 0;
        halt_req = 1; branch_en = 1; start = 1;
        cyc();
        halt_req = 0; branch_en = 0; start = 0;
        cyc();
        tests++;
        if (state !== 2'b10 || ir_pc !== 4'd4 || address !== 4'd5 || ir_valid !== 1'b1) begin
            fails++;
            $display("FAIL wait_hold: st=%0d pc=%0d a=%0d v=%0b required 2/4/5/1",
                     state, ir_pc, address, ir_valid);
        end
        ext_ack = 0; cyc();
        tests++;
        if (state !== 2'b10) begin
            fails++;
            $display("FAIL wait_ack_low: st=%0d required 2", state);
        end
        ext_ack = 1; cyc();
        tests++;
        if (state !== 2'b01 || ir_pc !== 4'd5 || ir !== 25'd5 || address !== 4'd6) begin
            fails++;
            $display("FAIL wait_release: st=%0d pc=%0d ir=%0d a=%0d required 1/5/5/6",
                     state, ir_pc, ir, address);
        end
        ext_ack = 0;
    endtask

    task automatic test_halt();
        run_to(4'd7);
        halt_req = 1; branch_en = 1; branch_abs = 1; branch_off = 4'd2;
        cyc();
        halt_req = 0; branch_en = 0; branch_abs = 0;
        cyc();
        tests++;
        if (state !== 2'b11 || halted !== 1'b1 || address !== 4'd8 ||
            ir_valid !== 1'b0 || ir !== 25'd7) begin
            fails++;
            $display("FAIL halt: st=%0d h=%0b a=%0d v=%0b ir=%0d required 3/1/8/0/7",
                     state, halted, address, ir_valid, ir);
        end
        start = 1; cyc(); start = 0;
        tests++;
        if (state !== 2'b00 || halted !== 1'b0 || address !== 4'd0 || ir_valid !== 1'b0) begin
            fails++;
            $display("FAIL halt_exit: st=%0d h=%0b a=%0d v=%0b required 0/0/0/0",
                     state, halted, address, ir_valid);
        end
        start = 1; cyc(); start = 0;
        tests++;
        if (state !== 2'b01 || ir !== 25'd0 || ir_pc !== 4'd0 || ir_valid !== 1'b1) begin
            fails++;
            $display("FAIL restart: st=%0d ir=%0d pc=%0d v=%0b required 1/0/0/1",
                     state, ir, ir_pc, ir_valid);
        end
    endtask

    task automatic test_reset_wait_halt();
        run_to(4'd2);
        wait_req = 1; ext_ack = 1; cyc(); wait_req = 0;
        reset = 1; cyc(); reset = 0; ext_ack = 0;
        tests++;
        if ({state, halted, ir_valid, address, ir_pc, ir} !== 36'd0) begin
            fails++;
            $display("FAIL reset_wait: st=%0d h=%0b v=%0b a=%0d pc=%0d ir=%0d required all 0",
                     state, halted, ir_valid, address, ir_pc, ir);
        end
        start = 1; cyc(); start = 0;
        run_to(4'd3);
        halt_req = 1; cyc(); halt_req = 0;
        reset = 1; cyc(); reset = 0;
        tests++;
        if ({state, halted, ir_valid, address, ir_pc, ir} !== 36'd0) begin
            fails++;
            $display("FAIL reset_halt: st=%0d h=%0b v=%0b a=%0d pc=%0d ir=%0d required all 0",
                     state, halted, ir_valid, address, ir_pc, ir);
        end
    endtask

    initial begin
        reset = 0; start = 0; branch_en = 0; branch_abs = 0;
        branch_off = 0; wait_req = 0; ext_ack = 0; halt_req = 0;
        #2;
        test_reset();
        test_sequential();
        test_start_ignored();
        test_branch_rel();
        test_wrap_and_abs();
        test_wait();
        test_halt();
        test_reset_wait_halt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
